// File: rtl/req_arbiter8.sv
// req_arbiter8: eight-requester arbiter on active-low request lines.
// Fixed priority (line 7 highest) or descending round-robin from a rotating
// pointer. A grant is held until done, withdrawal of the granted line, or
// HOLD_MAX cycles elapse. All outputs are registered.
module req_arbiter8 #(
   parameter int HOLD_MAX = 15
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] req_n,
   input  logic       mode,
   input  logic       done,
   output logic       gnt_valid,
   output logic [2:0] gnt_idx,
   output logic [7:0] gnt_onehot,
   output logic       timeout,
   output logic       busy
);

   localparam int CW = $clog2(HOLD_MAX + 1);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t        state;
   logic [2:0]    ptr;
   logic [CW-1:0] hold_cnt;

   logic [7:0]    req;
   logic          any_req;
   logic [2:0]    win_fixed;
   logic [2:0]    win_rr;
   logic [2:0]    win_idx;
   logic [7:0]    win_onehot;
   logic          withdrawn;
   logic          expire;

   assign req       = ~req_n;
   assign any_req   = |req;
   assign win_idx   = mode ? win_rr : win_fixed;
   assign withdrawn = req_n[gnt_idx];
   assign expire    = (hold_cnt == CW'(HOLD_MAX - 1));

   // Fixed priority: the highest-index active request wins (later hits override).
   always_comb begin
      win_fixed = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (req[i]) win_fixed = 3'(i);
      end
   end

   // Round-robin: search ptr, ptr-1, ... mod 8; the nearest to ptr is applied last.
   always_comb begin
      logic [2:0] cand;
      cand   = 3'd0;
      win_rr = 3'd0;
      for (int j = 7; j >= 0; j--) begin
         cand = ptr - 3'(j);
         if (req[cand]) win_rr = cand;
      end
   end

   // One-hot decode of the selected winner, registered alongside the index.
   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_dec
         assign win_onehot[gi] = (win_idx == 3'(gi));
      end
   endgenerate

   // Two-state grant FSM with registered outputs, hold counter and pointer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         gnt_valid  <= 1'b0;
         gnt_idx    <= 3'd0;
         gnt_onehot <= 8'd0;
         timeout    <= 1'b0;
         busy       <= 1'b0;
         ptr        <= 3'd7;
         hold_cnt   <= '0;
      end else begin
         timeout <= 1'b0;
         case (state)
            IDLE: begin
               if (any_req) begin
                  gnt_idx    <= win_idx;
                  gnt_onehot <= win_onehot;
                  gnt_valid  <= 1'b1;
                  busy       <= 1'b1;
                  hold_cnt   <= '0;
                  state      <= GRANT;
               end
            end
            GRANT: begin
               if (done || withdrawn || expire) begin
                  // gnt_idx is left as-is so the last winner stays visible.
                  gnt_valid  <= 1'b0;
                  busy       <= 1'b0;
                  gnt_onehot <= 8'd0;
                  ptr        <= gnt_idx - 3'd1;
                  timeout    <= !done && !withdrawn;
                  state      <= IDLE;
               end else begin
                  hold_cnt <= hold_cnt + CW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_req_arbiter8.sv
// tb_req_arbiter8: scoreboard bench for req_arbiter8 with HOLD_MAX = 4.
// Stimulus pushes the expected grant index and release outcome; a monitor
// pops and compares them when gnt_valid rises and falls.
module tb_req_arbiter8;

   localparam int HM = 4;

   logic       clk;
   logic       rst_n;
   logic [7:0] req_n;
   logic       mode;
   logic       done;
   logic       gnt_valid;
   logic [2:0] gnt_idx;
   logic [7:0] gnt_onehot;
   logic       timeout;
   logic       busy;

   typedef struct {
      logic to;
      int   len;
   } rel_t;

   int   grant_q[$];
   rel_t rel_q[$];
   int   n_vec = 0;
   int   n_err = 0;

   req_arbiter8 #(.HOLD_MAX(HM)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_n      (req_n),
      .mode       (mode),
      .done       (done),
      .gnt_valid  (gnt_valid),
      .gnt_idx    (gnt_idx),
      .gnt_onehot (gnt_onehot),
      .timeout    (timeout),
      .busy       (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Wait (bounded) at falling edges until gnt_valid reaches v.
   task automatic wait_valid(input logic v);
      int n;
      n = 0;
      while (gnt_valid !== v && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("wait_valid", 32'(gnt_valid), 32'(v));
   endtask

   // Wait for a grant, then assert done so the grant lasts exactly len cycles.
   task automatic serve(input int len);
      rel_t r;
      wait_valid(1'b1);
      r.to  = 1'b0;
      r.len = len;
      rel_q.push_back(r);
      repeat (len - 1) @(negedge clk);
      done = 1'b1;
      @(negedge clk);
      done = 1'b0;
   endtask

   // Monitor: compare grant and release events against the scoreboard.
   initial begin
      logic prev_valid;
      logic just_fell;
      int   len;
      int   e;
      logic [2:0] idx_at_grant;
      rel_t r;
      prev_valid   = 1'b0;
      just_fell    = 1'b0;
      len          = 0;
      idx_at_grant = 3'd0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_valid = 1'b0;
            just_fell  = 1'b0;
            len        = 0;
         end else begin
            if (gnt_valid && !prev_valid) begin
               len          = 0;
               idx_at_grant = gnt_idx;
               $display("grant idx=%0d onehot=%b", gnt_idx, gnt_onehot);
               if (grant_q.size() == 0) begin
                  check("grant_extra", 32'(grant_q.size()), 32'd1);
               end else begin
                  e = grant_q.pop_front();
                  check("gnt_idx", 32'(gnt_idx), 32'(e));
                  check("gnt_onehot", 32'(gnt_onehot), 32'(8'd1 << e));
                  check("busy_on", 32'(busy), 32'd1);
                  check("timeout_in_grant", 32'(timeout), 32'd0);
               end
            end
            if (gnt_valid) len++;
            if (!gnt_valid && prev_valid) begin
               $display("release idx=%0d len=%0d timeout=%0d", gnt_idx, len, timeout);
               if (rel_q.size() == 0) begin
                  check("release_extra", 32'(rel_q.size()), 32'd1);
               end else begin
                  r = rel_q.pop_front();
                  check("timeout_at_release", 32'(timeout), 32'(r.to));
                  check("grant_len", 32'(len), 32'(r.len));
                  check("onehot_cleared", 32'(gnt_onehot), 32'd0);
                  check("idx_kept", 32'(gnt_idx), 32'(idx_at_grant));
                  check("busy_off", 32'(busy), 32'd0);
               end
               just_fell = 1'b1;
            end else begin
               if (just_fell) check("timeout_one_cycle", 32'(timeout), 32'd0);
               just_fell = 1'b0;
            end
            prev_valid = gnt_valid;
         end
      end
   end

   // Global time bound so the run always terminates.
   initial begin
      #200000;
      $display("FAIL watchdog: got no_finish expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rel_t r;
      rst_n = 1'b0;
      req_n = 8'hFF;
      mode  = 1'b0;
      done  = 1'b0;
      repeat (2) @(negedge clk);

      // Reset state.
      check("rst_valid",  32'(gnt_valid),  32'd0);
      check("rst_idx",    32'(gnt_idx),    32'd0);
      check("rst_onehot", 32'(gnt_onehot), 32'd0);
      check("rst_timeout",32'(timeout),    32'd0);
      check("rst_busy",   32'(busy),       32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Withdrawal: requester 3 granted, bit 3 rises in its second cycle.
      grant_q.push_back(3);
      r.to = 1'b0; r.len = 2;
      rel_q.push_back(r);
      req_n = 8'hF7;
      wait_valid(1'b1);
      @(negedge clk);
      req_n = 8'hFF;
      @(negedge clk);
      // Pointer is now 2: round-robin with all requesting must pick 2.
      grant_q.push_back(2);
      mode  = 1'b1;
      req_n = 8'h00;
      serve(1);

      // Reset mid-grant: ptr is 1, so only-7 requesting still yields 7.
      grant_q.push_back(7);
      req_n = 8'h7F;
      wait_valid(1'b1);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_valid",  32'(gnt_valid),  32'd0);
      check("async_rst_onehot", 32'(gnt_onehot), 32'd0);
      check("async_rst_idx",    32'(gnt_idx),    32'd0);
      check("async_rst_busy",   32'(busy),       32'd0);
      req_n = 8'hFF;
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);

      // Round-robin from ptr = 7 with everyone requesting.
      for (int k = 0; k < 9; k++) grant_q.push_back((7 - k + 8) % 8);
      mode  = 1'b1;
      req_n = 8'h00;
      for (int k = 0; k < 9; k++) serve(1);
      req_n = 8'hFF;
      mode  = 1'b0;
      @(negedge clk);

      // Fixed priority: requesters 6, 4, 0; 6 is re-granted each time.
      for (int k = 0; k < 3; k++) grant_q.push_back(6);
      req_n = 8'b1010_1110;
      for (int k = 0; k < 3; k++) serve(2);
      grant_q.push_back(4);
      req_n = 8'b1110_1110;
      serve(2);
      req_n = 8'hFF;
      @(negedge clk);

      // Timeout on requester 1, then done exactly at expiry.
      grant_q.push_back(1);
      r.to = 1'b1; r.len = HM;
      rel_q.push_back(r);
      grant_q.push_back(1);
      req_n = 8'hFD;
      wait_valid(1'b1);
      wait_valid(1'b0);
      serve(HM);

      // Withdrawal coincident with expiry: no timeout.
      grant_q.push_back(1);
      wait_valid(1'b1);
      r.to = 1'b0; r.len = HM;
      rel_q.push_back(r);
      repeat (HM - 1) @(negedge clk);
      req_n = 8'hFF;
      @(negedge clk);
      repeat (4) @(negedge clk);

      check("grant_q_drained",   32'(grant_q.size()), 32'd0);
      check("release_q_drained", 32'(rel_q.size()),   32'd0);
      check("idle_valid",        32'(gnt_valid),      32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
